bcpu_shared_mem_responder: RTL and testbench

Shared-memory responder serving the external address space of BCPU16 cores. It sits outside the per-core local BRAM and receives LOAD/STORE requests from two requesters, typically two 4-core CPUs sharing memory. Each request targets an address with non-zero bits above PC_WIDTH. The block arbitrates one request per cycle into a private single-port RAM. It returns a one-cycle response pulse to the requester, with the same two-cycle latency as local memory.

---
 rtl/bcpu_shared_mem_responder_if.sv | 52 +++++
 rtl/bcpu_shared_mem_responder.sv | 176 +++++++++++++++++
 tb/tb_bcpu_shared_mem_responder.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bcpu_shared_mem_responder_if.sv
// ---------------------------------------------------------------------------
// bcpu_shared_mem_responder_if
//
// Bus bundle between two BCPU16 requesters and the shared-memory responder.
// Each requester n (0, 1) owns one request channel and one response channel:
//   REQn_VALID / REQn_READY  request handshake (VALID held until READY)
//   REQn_WREN                1 = STORE, 0 = LOAD
//   REQn_ADDR                word address in shared RAM
//   REQn_WRDATA              store data
//   RSPn_VALID               one-cycle response pulse, no backpressure
//   RSPn_DATA                load data, 0 for store acks and when idle
//
// Modports:
//   master : requester side (drives REQ*, samples READY and RSP*)
//   slave  : responder side (samples REQ*, drives READY and RSP*)
// ---------------------------------------------------------------------------
interface bcpu_shared_mem_responder_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
);

  logic                  REQ0_VALID;
  logic                  REQ0_WREN;
  logic [ADDR_WIDTH-1:0] REQ0_ADDR;
  logic [DATA_WIDTH-1:0] REQ0_WRDATA;
  logic                  REQ0_READY;
  logic                  RSP0_VALID;
  logic [DATA_WIDTH-1:0] RSP0_DATA;

  logic                  REQ1_VALID;
  logic                  REQ1_WREN;
  logic [ADDR_WIDTH-1:0] REQ1_ADDR;
  logic [DATA_WIDTH-1:0] REQ1_WRDATA;
  logic                  REQ1_READY;
  logic                  RSP1_VALID;
  logic [DATA_WIDTH-1:0] RSP1_DATA;

  modport master (
    output REQ0_VALID, REQ0_WREN, REQ0_ADDR, REQ0_WRDATA,
    output REQ1_VALID, REQ1_WREN, REQ1_ADDR, REQ1_WRDATA,
    input  REQ0_READY, RSP0_VALID, RSP0_DATA,
    input  REQ1_READY, RSP1_VALID, RSP1_DATA
  );

  modport slave (
    input  REQ0_VALID, REQ0_WREN, REQ0_ADDR, REQ0_WRDATA,
    input  REQ1_VALID, REQ1_WREN, REQ1_ADDR, REQ1_WRDATA,
    output REQ0_READY, RSP0_VALID, RSP0_DATA,
    output REQ1_READY, RSP1_VALID, RSP1_DATA
  );

endinterface : bcpu_shared_mem_responder_if

// File: rtl/bcpu_shared_mem_responder.sv
// ---------------------------------------------------------------------------
// bcpu_shared_mem_responder
//
// Shared-memory responder for the external address space of BCPU16 cores.
// Two requesters issue LOAD/STORE requests; one request per cycle is granted
// into a private single-port RAM and answered with a one-cycle response
// pulse on the requester's own port, two cycles after the handshake edge
// (same latency as the cores' local BRAM).
//
// Pipeline:
//   accept edge t  : store written to RAM, RAM read captured, tag -> S1
//   edge t+1 (S1)  : read data register loaded, tag -> S2
//   edge t+2 (S2)  : response registers loaded, RSPp_VALID high until t+3
//
// Ports:
//   CLK    in  clock, rising edge
//   RESET  in  asynchronous reset, active-high; drops in-flight responses
//              and forces READY low while asserted
//   bus    slave modport of bcpu_shared_mem_responder_if (REQ*/RSP* of
//          both requesters)
//
// Parameters:
//   DATA_WIDTH  memory word width (default 16)
//   ADDR_WIDTH  RAM address width, depth = 2**ADDR_WIDTH (default 10)
//
// Build option:
//   BCPU_SHARED_MEM_RR_ARB_EN  defined   -> round-robin arbitration
//                              undefined -> fixed priority, port 0 wins
// ---------------------------------------------------------------------------
module bcpu_shared_mem_responder #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                            CLK,
  input  logic                            RESET,
  bcpu_shared_mem_responder_if.slave      bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // Pipeline tag travelling alongside each accepted request.
  typedef struct packed {
    logic valid;
    logic port;      // 0 = requester 0, 1 = requester 1
    logic is_store;
  } tag_t;

  // -------------------------------------------------------------------------
  // Arbiter
  // -------------------------------------------------------------------------
  logic w_grant0;
  logic w_grant1;
  logic w_hs;

`ifdef BCPU_SHARED_MEM_RR_ARB_EN
  // r_prio names the port that wins the next conflict.
  logic r_prio;

  // NOTE: every output of an always_comb gets a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (!RESET) begin
      w_grant0 = bus.REQ0_VALID && (!bus.REQ1_VALID || !r_prio);
      w_grant1 = bus.REQ1_VALID && (!bus.REQ0_VALID ||  r_prio);
    end
  end

  // After a handshake the other port becomes the preferred one.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_prio <= 1'b0;
    end else if (w_hs) begin
      r_prio <= w_grant0;
    end
  end
`else
  // Fixed priority: port 0 always wins; port 1 only when port 0 is idle.
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (!RESET) begin
      w_grant0 = bus.REQ0_VALID;
      w_grant1 = bus.REQ1_VALID && !bus.REQ0_VALID;
    end
  end
`endif

  // A grant is only ever raised on a valid port, so a grant is a handshake.
  assign w_hs           = w_grant0 || w_grant1;
  assign bus.REQ0_READY = w_grant0;
  assign bus.REQ1_READY = w_grant1;

  // -------------------------------------------------------------------------
  // Request mux: the granted port's fields drive the RAM
  // -------------------------------------------------------------------------
  logic                  w_wren;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wrdata;

  always_comb begin
    w_wren   = 1'b0;
    w_addr   = bus.REQ0_ADDR;
    w_wrdata = bus.REQ0_WRDATA;
    if (w_grant1) begin
      w_wren   = bus.REQ1_WREN;
      w_addr   = bus.REQ1_ADDR;
      w_wrdata = bus.REQ1_WRDATA;
    end else if (w_grant0) begin
      w_wren   = bus.REQ0_WREN;
    end
  end

  // -------------------------------------------------------------------------
  // Single-port RAM, read-first, plus S1 read data register
  // -------------------------------------------------------------------------
  // NOTE: the RAM array is deliberately kept out of the reset domain so it
  // maps onto block RAM; its contents start at zero from configuration and
  // survive RESET.
  logic [DATA_WIDTH-1:0] r_mem [DEPTH] = '{default: '0};
  logic [DATA_WIDTH-1:0] r_ram_q;
  logic [DATA_WIDTH-1:0] r_rd_data;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; that is what lets a load issued one cycle after
  // a store observe the stored word while a load issued in the same cycle as
  // a later store still observes the older word.
  always_ff @(posedge CLK) begin
    if (w_hs) begin
      if (w_wren) begin
        r_mem[w_addr] <= w_wrdata;
      end
      r_ram_q <= r_mem[w_addr];
    end
    r_rd_data <= r_ram_q;
  end

  // -------------------------------------------------------------------------
  // Tag pipeline and registered response outputs
  // -------------------------------------------------------------------------
  tag_t                  r_s1;
  tag_t                  r_s2;
  logic                  r_rsp0_valid;
  logic                  r_rsp1_valid;
  logic [DATA_WIDTH-1:0] r_rsp0_data;
  logic [DATA_WIDTH-1:0] r_rsp1_data;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_s1         <= '0;
      r_s2         <= '0;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_rsp0_data  <= '0;
      r_rsp1_data  <= '0;
    end else begin
      r_s1.valid    <= w_hs;
      r_s1.port     <= w_grant1;
      r_s1.is_store <= w_hs && w_wren;
      r_s2          <= r_s1;

      r_rsp0_valid  <= r_s2.valid && !r_s2.port;
      r_rsp1_valid  <= r_s2.valid &&  r_s2.port;
      // Store acks and idle cycles present zero data.
      r_rsp0_data   <= (r_s2.valid && !r_s2.port && !r_s2.is_store) ? r_rd_data : '0;
      r_rsp1_data   <= (r_s2.valid &&  r_s2.port && !r_s2.is_store) ? r_rd_data : '0;
    end
  end

  assign bus.RSP0_VALID = r_rsp0_valid;
  assign bus.RSP1_VALID = r_rsp1_valid;
  assign bus.RSP0_DATA  = r_rsp0_data;
  assign bus.RSP1_DATA  = r_rsp1_data;

endmodule : bcpu_shared_mem_responder

// File: tb/tb_bcpu_shared_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_bcpu_shared_mem_responder
//
// Directed bench for bcpu_shared_mem_responder. Inputs change 1 ns after a
// rising edge; outputs are sampled in the same low-risk window. Expected
// values are hand-computed constants; arbitration expectations follow
// BCPU_SHARED_MEM_RR_ARB_EN when it is defined for the build.
// ---------------------------------------------------------------------------
module tb_bcpu_shared_mem_responder;

  localparam int DW = 16;
  localparam int AW = 10;

  logic CLK;
  logic RESET;

  int n_checks;
  int n_fail;

  bcpu_shared_mem_responder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

  bcpu_shared_mem_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive0(input logic v, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
    bus.REQ0_VALID  = v;
    bus.REQ0_WREN   = we;
    bus.REQ0_ADDR   = a;
    bus.REQ0_WRDATA = d;
  endtask

  task automatic drive1(input logic v, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
    bus.REQ1_VALID  = v;
    bus.REQ1_WREN   = we;
    bus.REQ1_ADDR   = a;
    bus.REQ1_WRDATA = d;
  endtask

  task automatic idle();
    drive0(1'b0, 1'b0, '0, '0);
    drive1(1'b0, 1'b0, '0, '0);
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    logic [1:0]    rdy;
    logic [2*DW+1:0] rsp;
    RESET = 1'b1;
    // Port 0 holds a store that must not commit; port 1 random.
    drive0(1'b1, 1'b1, 10'h020, 16'hDEAD);
    drive1(1'b1, 1'($urandom), AW'($urandom), DW'($urandom));
    for (int i = 0; i < 3; i++) begin
      tick();
      rdy = {bus.REQ1_READY, bus.REQ0_READY};
      if (rdy !== 2'b00) begin
        n_fail++;
        $display("FAIL reset_ready[%0d]: got %b, expected 00", i, rdy);
      end
      n_checks++;
      rsp = {bus.RSP0_VALID, bus.RSP0_DATA, bus.RSP1_VALID, bus.RSP1_DATA};
      if (rsp !== '0) begin
        n_fail++;
        $display("FAIL reset_rsp[%0d]: got %h, expected 0", i, rsp);
      end
      n_checks++;
    end
    RESET = 1'b0;
    idle();
    drive1(1'b1, 1'b0, 10'h000, 16'h0000);
    #1;
    rdy = {bus.REQ1_READY, bus.REQ0_READY};
    if (rdy !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_release_ready1: got %b, expected 10", rdy);
    end
    n_checks++;
    idle();
    tick();
    // The store held during reset must not have landed.
    drive0(1'b1, 1'b0, 10'h020, 16'h0000);
    tick();
    idle();
    tick();
    tick();
    if ({bus.RSP0_VALID, bus.RSP0_DATA} !== {1'b1, 16'h0000}) begin
      n_fail++;
      $display("FAIL reset_store_blocked: got %b/%h, expected 1/0000",
               bus.RSP0_VALID, bus.RSP0_DATA);
    end
    n_checks++;
    tick();
  endtask

  // -------------------------------------------------------------------------
  task automatic test_store_load();
    logic [1:0] rdy;
    drive0(1'b1, 1'b1, 10'h005, 16'hBEEF);
    #1;
    rdy = {bus.REQ1_READY, bus.REQ0_READY};
    if (rdy !== 2'b01) begin
      n_fail++;
      $display("FAIL sl_ready0: got %b, expected 01", rdy);
    end
    n_checks++;
    tick();                                   // store accepted at t
    drive0(1'b1, 1'b0, 10'h005, 16'h0000);
    tick();                                   // load accepted at t+1
    idle();
    tick();                                   // after t+2
    if ({bus.RSP0_VALID, bus.RSP0_DATA, bus.RSP1_VALID, bus.RSP1_DATA}
        !== {1'b1, 16'h0000, 1'b0, 16'h0000}) begin
      n_fail++;
      $display("FAIL sl_store_ack: got %b/%h rsp1 %b/%h, expected 1/0000 rsp1 0/0000",
               bus.RSP0_VALID, bus.RSP0_DATA, bus.RSP1_VALID, bus.RSP1_DATA);
    end
    n_checks++;
    tick();                                   // after t+3
    if ({bus.RSP0_VALID, bus.RSP0_DATA, bus.RSP1_VALID, bus.RSP1_DATA}
        !== {1'b1, 16'hBEEF, 1'b0, 16'h0000}) begin
      n_fail++;
      $display("FAIL sl_load_data: got %b/%h rsp1 %b/%h, expected 1/beef rsp1 0/0000",
               bus.RSP0_VALID, bus.RSP0_DATA, bus.RSP1_VALID, bus.RSP1_DATA);
    end
    n_checks++;
    tick();
    if ({bus.RSP0_VALID, bus.RSP0_DATA} !== {1'b0, 16'h0000}) begin
      n_fail++;
      $display("FAIL sl_pulse_end: got %b/%h, expected 0/0000",
               bus.RSP0_VALID, bus.RSP0_DATA);
    end
    n_checks++;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_streaming();
    logic [DW-1:0] exp_d [3];
    exp_d[0] = 16'h1111;
    exp_d[1] = 16'h2222;
    exp_d[2] = 16'h3333;
    for (int i = 0; i < 3; i++) begin
      drive1(1'b1, 1'b1, AW'(i + 1), exp_d[i]);
      tick();
    end
    idle();
    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      drive1(1'b1, 1'b0, AW'(i + 1), 16'h0000);
      tick();
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      if ({bus.RSP1_VALID, bus.RSP1_DATA, bus.RSP0_VALID}
          !== {1'b1, exp_d[i], 1'b0}) begin
        n_fail++;
        $display("FAIL stream_rsp[%0d]: got %b/%h rsp0v %b, expected 1/%h rsp0v 0",
                 i, bus.RSP1_VALID, bus.RSP1_DATA, bus.RSP0_VALID, exp_d[i]);
      end
      n_checks++;
      tick();
    end
    if ({bus.RSP1_VALID, bus.RSP1_DATA} !== {1'b0, 16'h0000}) begin
      n_fail++;
      $display("FAIL stream_end: got %b/%h, expected 0/0000",
               bus.RSP1_VALID, bus.RSP1_DATA);
    end
    n_checks++;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_contention();
    logic       exp_g0;
    logic       g0_hist [4];
    logic [1:0] rdy;
    logic [DW:0] exp_r0;
    logic [DW:0] exp_r1;
    drive0(1'b1, 1'b0, 10'h001, 16'h0000);
    drive1(1'b1, 1'b0, 10'h002, 16'h0000);
    for (int k = 0; k < 7; k++) begin
      if (k == 4) idle();
      #1;
      if (k < 4) begin
`ifdef BCPU_SHARED_MEM_RR_ARB_EN
        exp_g0 = ((k % 2) == 0);
`else
        exp_g0 = 1'b1;
`endif
        g0_hist[k] = exp_g0;
        rdy = {bus.REQ1_READY, bus.REQ0_READY};
        if (rdy !== {!exp_g0, exp_g0}) begin
          n_fail++;
          $display("FAIL cont_grant[%0d]: got %b, expected %b", k, rdy, {!exp_g0, exp_g0});
        end
        n_checks++;
      end
      if (k >= 3) begin
        exp_r0 = g0_hist[k-3] ? {1'b1, 16'h1111} : '0;
        exp_r1 = g0_hist[k-3] ? '0 : {1'b1, 16'h2222};
        if ({bus.RSP0_VALID, bus.RSP0_DATA, bus.RSP1_VALID, bus.RSP1_DATA}
            !== {exp_r0, exp_r1}) begin
          n_fail++;
          $display("FAIL cont_rsp[%0d]: got %b/%h %b/%h, expected %h %h", k - 3,
                   bus.RSP0_VALID, bus.RSP0_DATA, bus.RSP1_VALID, bus.RSP1_DATA,
                   exp_r0, exp_r1);
        end
        n_checks++;
      end
      tick();
    end
    tick();
  endtask

  // -------------------------------------------------------------------------
  task automatic test_raw();
    drive1(1'b1, 1'b1, 10'h3FF, 16'h1234);
    tick();                                   // store accepted at t
    idle();
    drive0(1'b1, 1'b0, 10'h3FF, 16'h0000);
    tick();                                   // load accepted at t+1
    idle();
    tick();                                   // after t+2
    if ({bus.RSP1_VALID, bus.RSP1_DATA, bus.RSP0_VALID}
        !== {1'b1, 16'h0000, 1'b0}) begin
      n_fail++;
      $display("FAIL raw_store_ack: got %b/%h rsp0v %b, expected 1/0000 rsp0v 0",
               bus.RSP1_VALID, bus.RSP1_DATA, bus.RSP0_VALID);
    end
    n_checks++;
    tick();                                   // after t+3
    if ({bus.RSP0_VALID, bus.RSP0_DATA, bus.RSP1_VALID}
        !== {1'b1, 16'h1234, 1'b0}) begin
      n_fail++;
      $display("FAIL raw_load: got %b/%h rsp1v %b, expected 1/1234 rsp1v 0",
               bus.RSP0_VALID, bus.RSP0_DATA, bus.RSP1_VALID);
    end
    n_checks++;
    tick();
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset_inflight();
    // In-flight load dropped.
    drive0(1'b1, 1'b0, 10'h005, 16'h0000);
    tick();                                   // load accepted at t
    idle();
    RESET = 1'b1;
    #2;
    RESET = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if ({bus.RSP0_VALID, bus.RSP0_DATA} !== {1'b0, 16'h0000}) begin
        n_fail++;
        $display("FAIL inflight_load_dropped[%0d]: got %b/%h, expected 0/0000",
                 i, bus.RSP0_VALID, bus.RSP0_DATA);
      end
      n_checks++;
    end
    // Store accepted before the reset pulse survives; its ack is dropped.
    drive0(1'b1, 1'b1, 10'h010, 16'hA5A5);
    tick();
    idle();
    RESET = 1'b1;
    #2;
    RESET = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.RSP0_VALID !== 1'b0) begin
        n_fail++;
        $display("FAIL inflight_ack_dropped[%0d]: got %b, expected 0", i, bus.RSP0_VALID);
      end
      n_checks++;
    end
    drive0(1'b1, 1'b0, 10'h010, 16'h0000);
    tick();
    idle();
    tick();
    tick();
    if ({bus.RSP0_VALID, bus.RSP0_DATA} !== {1'b1, 16'hA5A5}) begin
      n_fail++;
      $display("FAIL inflight_store_kept: got %b/%h, expected 1/a5a5",
               bus.RSP0_VALID, bus.RSP0_DATA);
    end
    n_checks++;
    tick();
  endtask

  // -------------------------------------------------------------------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    RESET    = 1'b0;
    idle();
    #1;
    test_reset();
    test_store_load();
    test_streaming();
    test_contention();
    test_raw();
    test_reset_inflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_bcpu_shared_mem_responder
